// File: rtl/mips_multi_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback and
// issues ALU operand selects, ALU op code and datapath write enables each cycle.
module mips_multi_control #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  output logic           pc_en,
  output logic           iord,
  output logic           mem_write,
  output logic           ir_write,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic           imm_zext,
  output logic [2:0]     alu_select,
  output logic [1:0]     pc_src,
  output logic           illegal_op,
  output logic [STW-1:0] state_dbg
);

  typedef enum logic [STW-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQEX  = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_J     = 6'h02;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPW-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;

  state_t     state_q, state_d;
  logic       funct_ok;
  logic [2:0] funct_sel;
  logic       pc_write;
  logic       branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state_dbg = state_q;

  // R-type funct decode shared by DECODE (legality) and REX (ALU op).
  always_comb begin
    funct_ok  = 1'b1;
    funct_sel = 3'b000;
    case (funct)
      6'h20:   funct_sel = 3'b000;
      6'h24:   funct_sel = 3'b001;
      6'h26:   funct_sel = 3'b010;
      6'h27:   funct_sel = 3'b100;
      6'h00:   funct_sel = 3'b101;
      6'h02:   funct_sel = 3'b110;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    alu_select = 3'b000;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_ok) state_d = S_REX;
            else          illegal_op = 1'b1;
          end
          OP_BEQ:                    state_d = S_BEQEX;
          OP_ADDI, OP_ANDI, OP_XORI: state_d = S_IMMEX;
          OP_J:                      state_d = S_JUMP;
          default:                   illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_REX: begin
        alu_src_a  = 1'b1;
        alu_select = funct_sel;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQEX: begin
        // xor of A and B gives zero=1 exactly when the operands are equal
        alu_src_a  = 1'b1;
        alu_select = 3'b010;
        pc_src     = 2'b01;
        branch     = 1'b1;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ANDI) begin
          alu_select = 3'b001;
          imm_zext   = 1'b1;
        end else if (opcode == OP_XORI) begin
          alu_select = 3'b010;
          imm_zext   = 1'b1;
        end
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    pc_en = pc_write | (branch & zero);

    // Reset holds FETCH but must not let its PC/IR loads through.
    if (reset) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
